// File: rtl/mcp4911_pkg.sv
// Shared types and constants for the MCP4911 DAC SPI driver.
// Holds the transaction state enum, frame/data widths, the positions of the
// configuration bits inside the 16-bit DAC command word, and a frame builder.
package mcp4911_pkg;

    localparam int unsigned FRAME_W = 16;
    localparam int unsigned DATA_W  = 10;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned BIT_W   = 5;

    // Configuration bit positions in the command word
    localparam int unsigned BIT_ZERO   = 15;
    localparam int unsigned BIT_BUF    = 14;
    localparam int unsigned BIT_GA_N   = 13;
    localparam int unsigned BIT_SHDN_N = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_SHIFT,
        ST_CS_HOLD,
        ST_LDAC,
        ST_GAP
    } state_t;

    // {0, BUF, GA_N, SHDN_N, d[9:0], 00}
    function automatic logic [FRAME_W-1:0] build_frame(
        input logic              vref_buf,
        input logic              gain_n,
        input logic              shdn_n,
        input logic [DATA_W-1:0] d
    );
        logic [FRAME_W-1:0] f;
        f              = '0;
        f[BIT_ZERO]    = 1'b0;
        f[BIT_BUF]     = vref_buf;
        f[BIT_GA_N]    = gain_n;
        f[BIT_SHDN_N]  = shdn_n;
        f[DATA_W+1:2]  = d;
        return f;
    endfunction

endpackage

// File: rtl/mcp4911_spi_sample_edge_sync.sv
// sample_edge_sync: 2-flop synchronizer plus rising-edge strobe.
// Ports: clk, reset (sync, active high), async_in (foreign-domain level),
//        strobe_c (one-cycle combinational strobe, 2 edges after the pin rises,
//        so the consumer acts on the 3rd edge).
// A level already high when reset releases never strobes: the detector only
// arms after it has seen a genuine synchronized low.
module sample_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic strobe_c
);

    logic sync_1;
    logic sync_2;
    logic sync_prev;
    logic fill_1;
    logic fill_2;
    logic armed;

    // Synchronizer, edge history and arming
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_1    <= 1'b0;
            sync_2    <= 1'b0;
            sync_prev <= 1'b0;
            fill_1    <= 1'b0;
            fill_2    <= 1'b0;
            armed     <= 1'b0;
        end else begin
            sync_1    <= async_in;
            sync_2    <= sync_1;
            sync_prev <= sync_2;
            // fill_2 marks sync_2 as holding a real sample, not the reset zero
            fill_1    <= 1'b1;
            fill_2    <= fill_1;
            if (fill_2 && !sync_2) begin
                armed <= 1'b1;
            end
        end
    end

    assign strobe_c = armed & sync_2 & ~sync_prev;

endmodule

// File: rtl/mcp4911_spi.sv
// mcp4911_spi: pushes LFO samples to an MCP4911 10-bit DAC over SPI mode 0.
// Ports: clk, reset (sync, active high), sample_clk (LFO-domain sample clock),
//        d_in[9:0] (sample), cs_n, sck, sdi, ldac_n (DAC pins),
//        busy (not idle), overrun (request dropped while a slot was pending).
// One request may wait in a single pending slot while a frame is in flight;
// a further request overwrites it and pulses overrun.
module mcp4911_spi
    import mcp4911_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 1,
    parameter int unsigned LDAC_CYCLES = 3,
    parameter bit          BUF         = 1'b0,
    parameter bit          GA_N        = 1'b1,
    parameter bit          SHDN_N      = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_clk,
    input  logic [DATA_W-1:0] d_in,
    output logic              cs_n,
    output logic              sck,
    output logic              sdi,
    output logic              ldac_n,
    output logic              busy,
    output logic              overrun
);

    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] LDAC_LAST = CNT_W'(LDAC_CYCLES - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_W - 1);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic [FRAME_W-1:0]  shreg;
    logic                pending;
    logic [DATA_W-1:0]   pend_data;

    logic                strobe_c;
    logic                start_c;
    logic [DATA_W-1:0]   start_data_c;
    logic [FRAME_W-1:0]  frame_c;
    logic                take_strobe_c;

    sample_edge_sync u_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (sample_clk),
        .strobe_c (strobe_c)
    );

    // Frame start decision: pending data has priority over a fresh strobe
    always_comb begin
        start_c      = 1'b0;
        start_data_c = d_in;
        if (state == ST_IDLE) begin
            if (pending) begin
                start_c      = 1'b1;
                start_data_c = pend_data;
            end else if (strobe_c) begin
                start_c = 1'b1;
            end
        end else if (state == ST_GAP && pending) begin
            start_c      = 1'b1;
            start_data_c = pend_data;
        end
        frame_c       = build_frame(BUF, GA_N, SHDN_N, start_data_c);
        // Any strobe not consumed directly by an idle start lands in the slot
        take_strobe_c = strobe_c && !(state == ST_IDLE && !pending);
    end

    // Transaction FSM, pending slot and registered pin drivers
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cs_n      <= 1'b1;
            sck       <= 1'b0;
            sdi       <= 1'b0;
            ldac_n    <= 1'b1;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            pending   <= 1'b0;
            pend_data <= '0;
            cnt       <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
        end else begin
            overrun <= 1'b0;

            if (take_strobe_c) begin
                pending   <= 1'b1;
                pend_data <= d_in;
                overrun   <= pending;
            end else if (start_c && pending) begin
                pending <= 1'b0;
            end

            if (start_c) begin
                state  <= ST_CS_SETUP;
                cs_n   <= 1'b0;
                sck    <= 1'b0;
                ldac_n <= 1'b1;
                busy   <= 1'b1;
                cnt    <= '0;
                shreg  <= frame_c;
                sdi    <= frame_c[FRAME_W-1];
            end else begin
                case (state)
                    ST_IDLE: begin
                        busy <= 1'b0;
                    end
                    ST_CS_SETUP: begin
                        if (cnt == DIV_LAST) begin
                            cnt     <= '0;
                            bit_cnt <= '0;
                            state   <= ST_SHIFT;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    ST_SHIFT: begin
                        if (cnt != DIV_LAST) begin
                            cnt <= cnt + CNT_W'(1);
                        end else begin
                            cnt <= '0;
                            if (!sck) begin
                                sck <= 1'b1;
                            end else begin
                                // Falling edge: the only point where sdi moves
                                sck <= 1'b0;
                                if (bit_cnt == BIT_LAST) begin
                                    state <= ST_CS_HOLD;
                                end else begin
                                    bit_cnt <= bit_cnt + BIT_W'(1);
                                    shreg   <= {shreg[FRAME_W-2:0], 1'b0};
                                    sdi     <= shreg[FRAME_W-2];
                                end
                            end
                        end
                    end
                    ST_CS_HOLD: begin
                        if (cnt == DIV_LAST) begin
                            cnt    <= '0;
                            cs_n   <= 1'b1;
                            sdi    <= 1'b0;
                            ldac_n <= 1'b0;
                            state  <= ST_LDAC;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    ST_LDAC: begin
                        if (cnt == LDAC_LAST) begin
                            cnt    <= '0;
                            ldac_n <= 1'b1;
                            state  <= ST_GAP;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    ST_GAP: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mcp4911_spi.sv
// Self-checking bench for mcp4911_spi: a default instance (CLK_DIV=1) and a
// CLK_DIV=4 instance share stimulus. Requests are logged with the clock edge
// on which they take effect; a queue-based busy-window model derives the
// expected DAC words and overrun count for each instance.
module tb_mcp4911_spi;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sample_clk = 1'b0;
    logic [9:0] d_in = '0;
    logic [1:0] cs_n_v, sck_v, sdi_v, ldac_v, busy_v, ovr_v;

    localparam int LDAC = 3;
    localparam int L0 = 1 * 34 + LDAC + 1;
    localparam int L1 = 4 * 34 + LDAC + 1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mcp4911_spi u_dut0 (
        .clk(clk), .reset(reset), .sample_clk(sample_clk), .d_in(d_in),
        .cs_n(cs_n_v[0]), .sck(sck_v[0]), .sdi(sdi_v[0]), .ldac_n(ldac_v[0]),
        .busy(busy_v[0]), .overrun(ovr_v[0])
    );

    mcp4911_spi #(.CLK_DIV(4)) u_dut1 (
        .clk(clk), .reset(reset), .sample_clk(sample_clk), .d_in(d_in),
        .cs_n(cs_n_v[1]), .sck(sck_v[1]), .sdi(sdi_v[1]), .ldac_n(ldac_v[1]),
        .busy(busy_v[1]), .overrun(ovr_v[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- pin monitors (one per instance) ----------------
    logic        mon_clr = 1'b0;
    logic [15:0] got0[$];
    logic [15:0] got1[$];
    logic [15:0] sh[2]      = '{16'h0, 16'h0};
    logic        sck_q[2]   = '{1'b0, 1'b0};
    logic        cs_q[2]    = '{1'b1, 1'b1};
    logic        sdi_hi[2]  = '{1'b0, 1'b0};
    int          nbits[2]   = '{0, 0};
    int          last_rise[2] = '{0, 0};
    int          sck_bad[2] = '{0, 0};
    int          sdi_bad[2] = '{0, 0};
    int          bits_bad[2] = '{0, 0};
    int          busy_cyc[2] = '{0, 0};
    int          ldac_cyc[2] = '{0, 0};
    int          ovr_cnt[2] = '{0, 0};

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (mon_clr) begin
                nbits[k] = 0; sck_bad[k] = 0; sdi_bad[k] = 0; bits_bad[k] = 0;
                busy_cyc[k] = 0; ldac_cyc[k] = 0; ovr_cnt[k] = 0; sh[k] = '0;
            end else begin
                if (sck_v[k] && !sck_q[k]) begin
                    if (nbits[k] > 0 && (cyc - last_rise[k]) != ((k == 0) ? 2 : 8))
                        sck_bad[k]++;
                    last_rise[k] = cyc;
                    sh[k] = {sh[k][14:0], sdi_v[k]};
                    nbits[k]++;
                    sdi_hi[k] = sdi_v[k];
                end else if (sck_v[k] && sdi_v[k] !== sdi_hi[k]) begin
                    sdi_bad[k]++;
                end
                if (cs_n_v[k] && !cs_q[k]) begin
                    if (k == 0) got0.push_back(sh[k]);
                    else        got1.push_back(sh[k]);
                    if (nbits[k] != 16) bits_bad[k]++;
                    nbits[k] = 0;
                end
                if (busy_v[k]) busy_cyc[k]++;
                if (!ldac_v[k]) ldac_cyc[k]++;
                if (ovr_v[k]) ovr_cnt[k]++;
            end
            sck_q[k] = sck_v[k];
            cs_q[k]  = cs_n_v[k];
        end
    end

    // ---------------- reference model ----------------
    int          ev_t[$];
    logic [9:0]  ev_d[$];
    logic [15:0] exp_q[$];
    int          exp_ovr;

    function automatic logic [15:0] word_of(input logic [9:0] d);
        return 16'h3000 | (16'(d) << 2);
    endfunction

    // A frame starting at edge s occupies the DUT until its gap edge s+L.
    task automatic run_model(input int len);
        int   g;
        int   e;
        bit   active;
        bit   pend;
        logic [9:0] pd;
        exp_q.delete();
        exp_ovr = 0;
        active = 0; pend = 0; g = 0; pd = '0;
        for (int i = 0; i < ev_t.size(); i++) begin
            e = ev_t[i];
            while (active && g < e) begin
                if (pend) begin
                    exp_q.push_back(word_of(pd)); g = g + len; pend = 0;
                end else begin
                    active = 0;
                end
            end
            if (!active) begin
                exp_q.push_back(word_of(ev_d[i])); g = e + len; active = 1;
            end else if (e == g) begin
                if (pend) begin
                    exp_q.push_back(word_of(pd)); pd = ev_d[i]; exp_ovr++; g = g + len;
                end else begin
                    exp_q.push_back(word_of(ev_d[i])); g = g + 1 + len;
                end
            end else begin
                if (pend) exp_ovr++;
                pd = ev_d[i]; pend = 1;
            end
        end
        if (active && pend) exp_q.push_back(word_of(pd));
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic rise(input logic [9:0] d, input int hi, input int lo, input bit log_ev);
        @(negedge clk);
        d_in = d;
        sample_clk = 1'b1;
        if (log_ev) begin
            ev_t.push_back(cyc + 3);
            ev_d.push_back(d);
        end
        repeat (hi) @(negedge clk);
        sample_clk = 1'b0;
        repeat (lo - 1) @(negedge clk);
    endtask

    task automatic wait_idle();
        int quiet = 0;
        int guard = 0;
        while (quiet < 4 && guard < 5000) begin
            @(negedge clk);
            guard++;
            if (busy_v == 2'b00 && cs_n_v == 2'b11) quiet++;
            else quiet = 0;
        end
        if (quiet < 4) check("idle_timeout", 32'(quiet), 32'd4);
        @(posedge clk);
    endtask

    task automatic clear_monitors();
        @(posedge clk); mon_clr = 1'b1;
        @(posedge clk); mon_clr = 1'b0;
        got0.delete(); got1.delete();
        ev_t.delete(); ev_d.delete();
    endtask

    task automatic check_segment(input string name);
        int nw;
        int len;
        logic [15:0] w;
        wait_idle();
        for (int k = 0; k < 2; k++) begin
            len = (k == 0) ? L0 : L1;
            run_model(len);
            nw = (k == 0) ? got0.size() : got1.size();
            check($sformatf("%s_k%0d_nwords", name, k), 32'(nw), 32'(exp_q.size()));
            for (int i = 0; i < nw && i < exp_q.size(); i++) begin
                w = (k == 0) ? got0[i] : got1[i];
                check($sformatf("%s_k%0d_word%0d", name, k, i), 32'(w), 32'(exp_q[i]));
            end
            check($sformatf("%s_k%0d_overrun", name, k), 32'(ovr_cnt[k]), 32'(exp_ovr));
            check($sformatf("%s_k%0d_busy_cyc", name, k), 32'(busy_cyc[k]), 32'(exp_q.size() * len));
            check($sformatf("%s_k%0d_ldac_cyc", name, k), 32'(ldac_cyc[k]), 32'(exp_q.size() * LDAC));
            check($sformatf("%s_k%0d_bitcount", name, k), 32'(bits_bad[k]), 32'd0);
            check($sformatf("%s_k%0d_sck_period", name, k), 32'(sck_bad[k]), 32'd0);
            check($sformatf("%s_k%0d_sdi_stable", name, k), 32'(sdi_bad[k]), 32'd0);
        end
        clear_monitors();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int c;
        int guard;

        // Reset values
        repeat (4) @(negedge clk);
        check("rst_cs_n", 32'(cs_n_v), 32'h3);
        check("rst_sck", 32'(sck_v), 32'h0);
        check("rst_sdi", 32'(sdi_v), 32'h0);
        check("rst_ldac_n", 32'(ldac_v), 32'h3);
        check("rst_busy", 32'(busy_v), 32'h0);
        check("rst_overrun", 32'(ovr_v), 32'h0);

        // sample_clk already high at reset release must not start a frame
        sample_clk = 1'b1;
        @(negedge clk); reset = 1'b0;
        repeat (20) @(negedge clk);
        check("high_at_release_busy", 32'(busy_v), 32'h0);
        sample_clk = 1'b0;
        repeat (6) @(negedge clk);
        clear_monitors();

        // Full-scale sample: cs_n falls on the third edge after the pin rises
        @(negedge clk);
        d_in = 10'h3FF; sample_clk = 1'b1; c = cyc;
        ev_t.push_back(c + 3); ev_d.push_back(10'h3FF);
        repeat (2) @(negedge clk);
        check("latency_pre_cs_n", 32'(cs_n_v[0]), 32'h1);
        @(negedge clk);
        check("latency_cs_n", 32'(cs_n_v[0]), 32'h0);
        sample_clk = 1'b0;
        guard = 0;
        while (cs_n_v[0] == 1'b0 && guard < 200) begin @(negedge clk); guard++; end
        check("cs_rise_seen", 32'(cs_n_v[0]), 32'h1);
        check("ldac_low_at_cs_rise", 32'(ldac_v[0]), 32'h0);
        repeat (2) @(negedge clk);
        check("ldac_low_third", 32'(ldac_v[0]), 32'h0);
        @(negedge clk);
        check("ldac_released", 32'(ldac_v[0]), 32'h1);
        wait_idle();
        check("word_3ff_k0", 32'(got0.size() > 0 ? got0[0] : 16'h0), 32'h3FFC);
        check("word_3ff_k1", 32'(got1.size() > 0 ? got1[0] : 16'h0), 32'h3FFC);
        check_segment("full_scale");

        // Consecutive sample periods of 1088 clk
        rise(10'h200, 544, 544, 1'b1);
        rise(10'h000, 544, 544, 1'b1);
        wait_idle();
        check("word_200", 32'(got0.size() > 0 ? got0[0] : 16'h0), 32'h3800);
        check("word_000", 32'(got0.size() > 1 ? got0[1] : 16'h0), 32'h3000);
        check_segment("periodic");

        // Slow SCK instance word
        rise(10'h155, 10, 200, 1'b1);
        wait_idle();
        check("word_155_div4", 32'(got1.size() > 0 ? got1[0] : 16'h0), 32'h3554);
        check_segment("div4");

        // Three requests inside one frame
        rise(10'h001, 4, 4, 1'b1);
        rise(10'h002, 4, 4, 1'b1);
        rise(10'h003, 4, 200, 1'b1);
        wait_idle();
        check("burst_word0", 32'(got0.size() > 0 ? got0[0] : 16'h0), 32'h3004);
        check("burst_word1", 32'(got0.size() > 1 ? got0[1] : 16'h0), 32'h300C);
        check("burst_overrun", 32'(ovr_cnt[0]), 32'd1);
        check_segment("burst");

        // Reset during bit 7 of the shift phase (default instance)
        @(negedge clk);
        d_in = 10'h2AA; sample_clk = 1'b1; c = cyc;
        repeat (4) @(negedge clk);
        sample_clk = 1'b0;
        while (cyc < c + 3 + 15) @(negedge clk);
        check("midshift_cs_n", 32'(cs_n_v[0]), 32'h0);
        reset = 1'b1;
        @(negedge clk);
        check("abort_cs_n", 32'(cs_n_v), 32'h3);
        check("abort_sck", 32'(sck_v), 32'h0);
        check("abort_ldac_n", 32'(ldac_v), 32'h3);
        check("abort_busy", 32'(busy_v), 32'h0);
        reset = 1'b0;
        repeat (60) @(negedge clk);
        @(posedge clk);
        check("abort_no_ldac", 32'(ldac_cyc[0] + ldac_cyc[1]), 32'd0);
        clear_monitors();
        rise(10'h0AB, 6, 200, 1'b1);
        check_segment("after_reset");

        // Randomized request spacing and data
        for (int i = 0; i < 40; i++) begin
            rise(10'($urandom), int'($urandom_range(2, 90)), int'($urandom_range(2, 90)), 1'b1);
        end
        check_segment("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
